// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: FSM state encoding and trace entry layout.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_t;

  // Trace entry: {REG_WRITE, MEM_WRITE, write_register, regWriteValue, memWriteValue}
  localparam int TR_W      = 38;
  localparam int TR_MV_LSB = 0;
  localparam int TR_RV_LSB = 16;
  localparam int TR_WR_LSB = 32;
  localparam int TR_MW_BIT = 36;
  localparam int TR_RW_BIT = 37;

  function automatic logic [TR_W-1:0] pack_trace(input logic rw, input logic mw,
                                                 input logic [3:0] wr,
                                                 input logic [15:0] rv,
                                                 input logic [15:0] mv);
    return {rw, mw, wr, rv, mv};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead synchronous FIFO for core write events, with a sticky drop flag.
module trace_fifo
  import run_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = TR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] rdata,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, do_push, do_pop;

  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == FULL_CNT);
    do_pop   = pop && !empty;
    // a pop on the same edge frees the slot, so a full FIFO still accepts the push
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
      if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
      if (push && !do_push)   ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

  assign valid    = !empty;
  assign rdata    = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow = ovf_q;

endmodule

// File: rtl/run_controller.sv
// Host-side run sequencer for the core: start pulse, halt/timeout detection,
// run-cycle measurement, final instruction count and write-event trace.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | waiting for go; results of last run held
//   ST_START   | start asserted to the core for START_LEN cycles
//   ST_RUN     | core running; cycle_count advancing
//   ST_DONE    | run ended by halt; one cycle, back to idle
//   ST_TIMEOUT | run ended by cycle limit; one cycle, back to idle
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CYC_W     = 20,
  parameter int MAX_CYC   = 100000,
  parameter int START_LEN = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             go,
  input  logic             halt,
  input  logic             REG_WRITE,
  input  logic [3:0]       write_register,
  input  logic [15:0]      regWriteValue,
  input  logic             MEM_WRITE,
  input  logic [15:0]      memWriteValue,
  input  logic [15:0]      InstCounter,
  output logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycle_count,
  output logic [15:0]      inst_count,
  input  logic             trace_rd,
  output logic             trace_valid,
  output logic [TR_W-1:0]  trace_data,
  output logic             trace_overflow
);

  localparam int SW = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam logic [SW-1:0]    START_LOAD = SW'(START_LEN - 1);
  localparam logic [CYC_W-1:0] LAST_CYC   = CYC_W'(MAX_CYC - 1);

  state_t           state_q, state_d;
  logic             go_q, go_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             done_q, done_d, to_q, to_d;
  logic             start_q, start_d, busy_q, busy_d;
  logic [15:0]      inst_q, inst_d;
  logic             fifo_clr, fifo_push;

  always_comb begin
    state_d  = state_q;
    go_d     = go;
    scnt_d   = scnt_q;
    cyc_d    = cyc_q;
    done_d   = done_q;
    to_d     = to_q;
    inst_d   = inst_q;
    fifo_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // go is registered first, so start appears two edges after go is seen
        if (go_q) begin
          state_d  = ST_START;
          scnt_d   = START_LOAD;
          cyc_d    = '0;
          done_d   = 1'b0;
          to_d     = 1'b0;
          fifo_clr = 1'b1;
        end
      end
      ST_START: begin
        if (scnt_q == '0) state_d = ST_RUN;
        else              scnt_d  = scnt_q - 1'b1;
      end
      ST_RUN: begin
        cyc_d = cyc_q + 1'b1;
        // cyc_q==0 marks the first RUN cycle, where a stale halt is ignored
        if (halt && (cyc_q != '0)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          inst_d  = InstCounter;
        end else if (cyc_q == LAST_CYC) begin
          state_d = ST_TIMEOUT;
          to_d    = 1'b1;
          inst_d  = InstCounter;
        end
      end
      ST_DONE, ST_TIMEOUT: state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
    start_d = (state_d == ST_START);
    busy_d  = (state_d == ST_START) || (state_d == ST_RUN);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      go_q    <= 1'b0;
      scnt_q  <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      inst_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      scnt_q  <= scnt_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      to_q    <= to_d;
      inst_q  <= inst_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign fifo_push = busy_q && (REG_WRITE || MEM_WRITE);

  trace_fifo #(.DEPTH(DEPTH), .W(TR_W)) u_trace_fifo (
    .clk      (CLK),
    .rst      (RESET),
    .clr      (fifo_clr),
    .push     (fifo_push),
    .wdata    (pack_trace(REG_WRITE, MEM_WRITE, write_register, regWriteValue, memWriteValue)),
    .pop      (trace_rd),
    .valid    (trace_valid),
    .rdata    (trace_data),
    .overflow (trace_overflow)
  );

  assign start       = start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = to_q;
  assign cycle_count = cyc_q;
  assign inst_count  = inst_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed and randomized runs of run_controller against a run-level reference model.
module tb_run_controller;

  localparam int DEPTH   = 16;
  localparam int CYC_W   = 20;
  localparam int MAX_CYC = 50;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             go = 1'b0, halt = 1'b1, trace_rd = 1'b0;
  logic             REG_WRITE = 1'b0, MEM_WRITE = 1'b0;
  logic [3:0]       write_register = '0;
  logic [15:0]      regWriteValue = '0, memWriteValue = '0, InstCounter = '0;
  logic             start, busy, done, timeout, trace_valid, trace_overflow;
  logic [CYC_W-1:0] cycle_count;
  logic [15:0]      inst_count;
  logic [37:0]      trace_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [37:0] mq[$];
  bit          m_ovf;

  bit          p_rw[64], p_mw[64], p_rd[64], p_go[64];
  logic [3:0]  p_wr[64];
  logic [15:0] p_rv[64], p_mv[64];

  always #5 CLK = ~CLK;

  run_controller #(.DEPTH(DEPTH), .CYC_W(CYC_W), .MAX_CYC(MAX_CYC), .START_LEN(1)) dut (
    .CLK(CLK), .RESET(RESET), .go(go), .halt(halt),
    .REG_WRITE(REG_WRITE), .write_register(write_register), .regWriteValue(regWriteValue),
    .MEM_WRITE(MEM_WRITE), .memWriteValue(memWriteValue), .InstCounter(InstCounter),
    .start(start), .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .inst_count(inst_count),
    .trace_rd(trace_rd), .trace_valid(trace_valid), .trace_data(trace_data),
    .trace_overflow(trace_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_head(input string tag);
    if (mq.size() > 0) begin
      chk({tag, ".valid"}, trace_valid, 1);
      chk({tag, ".data"}, trace_data, mq[0]);
    end else begin
      chk({tag, ".empty"}, trace_valid, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".start"}, start, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".timeout"}, timeout, 0);
    chk({tag, ".cycles"}, cycle_count, 0);
    chk({tag, ".inst"}, inst_count, 0);
    chk({tag, ".tvalid"}, trace_valid, 0);
    chk({tag, ".tdata"}, trace_data, 0);
    chk({tag, ".ovf"}, trace_overflow, 0);
  endtask

  task automatic plan_clear();
    for (int i = 0; i < 64; i++) begin
      p_rw[i] = 0; p_mw[i] = 0; p_rd[i] = 0; p_go[i] = 0;
      p_wr[i] = '0; p_rv[i] = '0; p_mv[i] = '0;
    end
  endtask

  task automatic plan_random(input bit with_go);
    for (int i = 0; i < 64; i++) begin
      p_rw[i] = ($urandom_range(0, 2) == 0);
      p_mw[i] = ($urandom_range(0, 3) == 0);
      p_rd[i] = ($urandom_range(0, 2) == 0);
      p_go[i] = with_go && ($urandom_range(0, 3) == 0);
      p_wr[i] = 4'($urandom);
      p_rv[i] = 16'($urandom);
      p_mv[i] = 16'($urandom);
    end
  endtask

  task automatic drive_idle();
    go = 0; REG_WRITE = 0; MEM_WRITE = 0; trace_rd = 0;
  endtask

  // One run: halt rises in RUN cycle halt_at (0 = never); early_halt holds halt
  // through START and RUN cycle 1; rst_at aborts the run with RESET at that cycle.
  task automatic do_run(input string name, input int halt_at, input bit early_halt, input int rst_at);
    int          c;
    bit          exp_done;
    logic [15:0] ic;
    exp_done = 0;
    ic = '0;
    trace_rd = 0;
    go = 1;
    step();
    chk({name, ".latency"}, start, 0);
    go = 0;
    step();
    mq.delete();
    m_ovf = 0;
    chk({name, ".start_on"}, start, 1);
    chk({name, ".busy_on"}, busy, 1);
    chk({name, ".done_clr"}, done, 0);
    chk({name, ".to_clr"}, timeout, 0);
    chk({name, ".ovf_clr"}, trace_overflow, 0);
    chk({name, ".fifo_clr"}, trace_valid, 0);
    chk({name, ".cyc_clr"}, cycle_count, 0);
    for (c = 0; c <= MAX_CYC; c++) begin
      halt = (early_halt && c <= 1) || (halt_at != 0 && c >= halt_at);
      REG_WRITE = p_rw[c]; MEM_WRITE = p_mw[c];
      write_register = p_wr[c]; regWriteValue = p_rv[c]; memWriteValue = p_mv[c];
      trace_rd = p_rd[c]; go = p_go[c];
      ic = 16'($urandom);
      InstCounter = ic;
      check_head(name);
      if (c == rst_at) begin
        #1 RESET = 1;
        #1 check_all_zero({name, ".midreset"});
        mq.delete();
        m_ovf = 0;
        drive_idle();
        #2 RESET = 0;
        return;
      end
      step();
      if (trace_rd && mq.size() > 0) void'(mq.pop_front());
      if (REG_WRITE || MEM_WRITE) begin
        if (mq.size() < DEPTH) mq.push_back({REG_WRITE, MEM_WRITE, write_register, regWriteValue, memWriteValue});
        else m_ovf = 1;
      end
      chk({name, ".ovf"}, trace_overflow, m_ovf);
      if (c >= 1 && ((halt && c >= 2) || c == MAX_CYC)) begin
        exp_done = halt && c >= 2;
        break;
      end
      chk({name, ".busy"}, busy, 1);
      chk({name, ".start_off"}, start, 0);
      chk({name, ".cycles"}, cycle_count, c);
    end
    drive_idle();
    chk({name, ".end_busy"}, busy, 0);
    chk({name, ".end_start"}, start, 0);
    chk({name, ".done"}, done, exp_done);
    chk({name, ".timeout"}, timeout, !exp_done);
    chk({name, ".cyc_final"}, cycle_count, c);
    chk({name, ".inst"}, inst_count, ic);
    InstCounter = 16'($urandom);
    for (int k = 0; k < 4; k++) begin
      step();
      chk({name, ".idle_start"}, start, 0);
      chk({name, ".idle_busy"}, busy, 0);
      chk({name, ".sticky_done"}, done, exp_done);
      chk({name, ".sticky_to"}, timeout, !exp_done);
      chk({name, ".hold_inst"}, inst_count, ic);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < DEPTH + 4; k++) begin
      trace_rd = 1;
      check_head({name, ".drain"});
      step();
      if (mq.size() > 0) void'(mq.pop_front());
    end
    trace_rd = 0;
    chk({name, ".drained"}, trace_valid, 0);
    chk({name, ".ovf_sticky"}, trace_overflow, m_ovf);
  endtask

  logic [37:0] e1;

  initial begin
    mq.delete();
    m_ovf = 0;
    plan_clear();
    // test 1: reset with halt high, halt rises in RUN cycle 6
    #12;
    check_all_zero("reset");
    @(negedge CLK) RESET = 0;
    step();
    step();
    check_all_zero("post_reset");
    do_run("t1", 6, 0, -1);
    drain("t1");

    // test 2: stale halt through START and RUN 1, real halt in RUN 2
    do_run("t2", 2, 1, -1);
    drain("t2");

    // test 3: no halt -> timeout at MAX_CYC
    halt = 0;
    do_run("t3", 0, 0, -1);
    drain("t3");

    // test 4: register write then combined write
    plan_clear();
    p_rw[1] = 1; p_wr[1] = 4'd3; p_rv[1] = 16'h1234; p_mv[1] = 16'h0000;
    p_rw[2] = 1; p_mw[2] = 1; p_wr[2] = 4'd7; p_rv[2] = 16'hBEEF; p_mv[2] = 16'h00AA;
    do_run("t4", 5, 0, -1);
    e1 = {1'b1, 1'b0, 4'd3, 16'h1234, 16'h0000};
    chk("t4.entry1", trace_data, e1);
    chk("t4.count", mq.size(), 2);
    drain("t4");

    // test 5: 17 pushes into a 16-deep FIFO, then push+pop while full
    plan_clear();
    for (int i = 0; i <= 17; i++) begin
      p_rw[i] = 1; p_wr[i] = 4'(i); p_rv[i] = 16'(16'hA000 + i); p_mv[i] = 16'($urandom);
    end
    p_rd[17] = 1;
    do_run("t5", 20, 0, -1);
    chk("t5.ovf", trace_overflow, 1);
    drain("t5");

    // test 6: reset mid-RUN, then a run with go pulses while busy
    plan_random(0);
    do_run("t6a", 0, 0, 7);
    check_all_zero("t6.after");
    plan_random(1);
    do_run("t6b", 12, 0, -1);
    drain("t6b");

    // randomized runs
    for (int r = 0; r < 5; r++) begin
      plan_random(1);
      do_run("rand", $urandom_range(2, 45), $urandom_range(0, 1) == 1, -1);
      drain("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
